// File: rtl/register_file_param.sv
// Two-read / one-write register file with write-to-read bypass, optional
// hardwired-zero register 0 and a handshaked dump engine that streams every register in order.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } dump_state_t;

  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic                  wr_commit_s;
  logic [DATA_WIDTH-1:0] rd_next_a_s;
  logic [DATA_WIDTH-1:0] rd_next_b_s;
  logic [ADDR_WIDTH-1:0] dump_addr_inc_s;

  dump_state_t           state_r;
  dump_state_t           state_next_s;
  logic                  valid_next_s;
  logic                  busy_next_s;
  logic                  done_next_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;
  logic [DATA_WIDTH-1:0] data_next_s;

  // Value a reader sees at this edge: zero register first, then the in-flight write, then the array.
  function automatic logic [DATA_WIDTH-1:0] port_value(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] value;
    if (ZERO_REG && (addr == ADDR_ZERO)) begin
      value = DATA_ZERO;
    end else if (we && (waddr == addr)) begin
      value = wdata;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  // Write qualification and next values for both read ports.
  always_comb begin
    wr_commit_s     = wr_en && !(ZERO_REG && (wr_addr == ADDR_ZERO));
    rd_next_a_s     = port_value(rd_addr_a, regs_r[rd_addr_a], wr_en, wr_addr, wr_data);
    rd_next_b_s     = port_value(rd_addr_b, regs_r[rd_addr_b], wr_en, wr_addr, wr_data);
    dump_addr_inc_s = dump_addr + ADDR_ONE;
  end

  // Register array storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (wr_commit_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Registered read ports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_a <= DATA_ZERO;
      rd_data_b <= DATA_ZERO;
    end else begin
      rd_data_a <= rd_next_a_s;
      rd_data_b <= rd_next_b_s;
    end
  end

  // Dump FSM next-state and next-output logic; a stalled beat simply keeps its registered values.
  always_comb begin
    state_next_s = state_r;
    valid_next_s = dump_valid;
    busy_next_s  = dump_busy;
    done_next_s  = 1'b0;
    addr_next_s  = dump_addr;
    data_next_s  = dump_data;
    case (state_r)
      IDLE: begin
        if (dump_start) begin
          state_next_s = STREAM;
          valid_next_s = 1'b1;
          busy_next_s  = 1'b1;
          addr_next_s  = ADDR_ZERO;
          data_next_s  = port_value(ADDR_ZERO, regs_r[ADDR_ZERO], wr_en, wr_addr, wr_data);
        end else begin
          state_next_s = IDLE;
        end
      end
      STREAM: begin
        if (dump_valid && dump_ready) begin
          if (dump_addr != LAST_IDX) begin
            addr_next_s = dump_addr_inc_s;
            data_next_s = port_value(dump_addr_inc_s, regs_r[dump_addr_inc_s],
                                     wr_en, wr_addr, wr_data);
          end else begin
            state_next_s = IDLE;
            valid_next_s = 1'b0;
            busy_next_s  = 1'b0;
            done_next_s  = 1'b1;
          end
        end else begin
          state_next_s = STREAM;
        end
      end
      default: begin
        state_next_s = IDLE;
        valid_next_s = 1'b0;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Dump FSM state and registered dump outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= ADDR_ZERO;
      dump_data  <= DATA_ZERO;
    end else begin
      state_r    <= state_next_s;
      dump_valid <= valid_next_s;
      dump_busy  <= busy_next_s;
      dump_done  <= done_next_s;
      dump_addr  <= addr_next_s;
      dump_data  <= data_next_s;
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: two instances (zero-register on / off) share stimulus; a reference
// model pushes expected read/dump results into queues that independent monitors drain.
module tb_register_file_param;

  logic        clock;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic        wr_en, dump_start, dump_ready;
  logic [31:0] wr_data;

  logic [31:0] rda_z, rdb_z, dd_z, rda_n, rdb_n, dd_n;
  logic [4:0]  da_z, da_n;
  logic        dv_z, db_z, dn_z, dv_n, db_n, dn_n;

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut_z (
    .clock(clock), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda_z), .rd_data_b(rdb_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(dump_start), .dump_valid(dv_z), .dump_ready(dump_ready),
    .dump_addr(da_z), .dump_data(dd_z), .dump_busy(db_z), .dump_done(dn_z));

  register_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dut_n (
    .clock(clock), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rda_n), .rd_data_b(rdb_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(dump_start), .dump_valid(dv_n), .dump_ready(dump_ready),
    .dump_addr(da_n), .dump_data(dd_n), .dump_busy(db_n), .dump_done(dn_n));

  typedef struct packed {
    logic [31:0] a0, a1, b0, b1;
    logic        done, busy;
  } exp_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] d0, d1;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];
  logic [31:0] mem [2][32];   // [0]: zero-register variant, [1]: plain variant
  int m_active, m_idx;
  int errors = 0;
  int checks = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mval(input int v, input int k, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
    if (v == 0 && k == 0) return 32'h0;
    if (we && int'(wa) == k) return wd;
    return mem[v][k];
  endfunction

  // One clock of stimulus; the model predicts what the coming edge produces.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb,
                      input logic st, input logic rdy);
    exp_t  e;
    beat_t bt;
    @(negedge clock);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    dump_start = st; dump_ready = rdy;
    e.a0 = mval(0, int'(ra), we, wa, wd);
    e.a1 = mval(1, int'(ra), we, wa, wd);
    e.b0 = mval(0, int'(rb), we, wa, wd);
    e.b1 = mval(1, int'(rb), we, wa, wd);
    e.done = 1'b0;
    if (m_active == 0) begin
      if (st) begin
        m_active = 1;
        m_idx = 0;
        bt.addr = 5'd0; bt.d0 = mval(0, 0, we, wa, wd); bt.d1 = mval(1, 0, we, wa, wd);
        beat_q.push_back(bt);
      end
    end else if (rdy) begin
      if (m_idx < 31) begin
        m_idx++;
        bt.addr = 5'(m_idx);
        bt.d0 = mval(0, m_idx, we, wa, wd);
        bt.d1 = mval(1, m_idx, we, wa, wd);
        beat_q.push_back(bt);
      end else begin
        m_active = 0;
        e.done = 1'b1;
      end
    end
    e.busy = (m_active != 0);
    if (we) begin
      if (wa != 5'd0) mem[0][wa] = wd;
      mem[1][wa] = wd;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_step(input logic rdy);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, rdy);
  endtask

  // Monitor: registered read ports and dump status, just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_a_zero", rda_z, e.a0);
        chk("rd_a_plain", rda_n, e.a1);
        chk("rd_b_zero", rdb_z, e.b0);
        chk("rd_b_plain", rdb_n, e.b1);
        chk("done_zero", 32'(dn_z), 32'(e.done));
        chk("done_plain", 32'(dn_n), 32'(e.done));
        chk("busy_zero", 32'(db_z), 32'(e.busy));
        chk("busy_plain", 32'(db_n), 32'(e.busy));
        chk("valid_zero", 32'(dv_z), 32'(e.busy));
        chk("valid_plain", 32'(dv_n), 32'(e.busy));
      end
    end
  end

  // Monitor: dump beats, compared at the edge that accepts them.
  initial begin
    beat_t bt;
    forever begin
      @(negedge clock);
      #3;
      if (dv_z && dump_ready) begin
        if (beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got addr %h with no beat outstanding", da_z);
        end else begin
          bt = beat_q.pop_front();
          chk("beat_addr_zero", 32'(da_z), 32'(bt.addr));
          chk("beat_addr_plain", 32'(da_n), 32'(bt.addr));
          chk("beat_data_zero", dd_z, bt.d0);
          chk("beat_data_plain", dd_n, bt.d1);
        end
      end
    end
  end

  initial begin
    int guard;
    logic [4:0] wa;
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    dump_start = 1'b0; dump_ready = 1'b0;
    m_active = 0; m_idx = 0;
    for (int v = 0; v < 2; v++) for (int k = 0; k < 32; k++) mem[v][k] = 32'h0;
    #2 reset = 1'b0;
    #1;
    chk("reset_rd_a", rda_z | rda_n, 32'h0);
    chk("reset_rd_b", rdb_z | rdb_n, 32'h0);
    chk("reset_dump_flags", {29'h0, dv_z | dv_n, db_z | db_n, dn_z | dn_n}, 32'h0);
    chk("reset_dump_addr", 32'(da_z | da_n), 32'h0);
    chk("reset_dump_data", dd_z | dd_n, 32'h0);
    @(negedge clock);
    #1 reset = 1'b1;

    // Write then read, same-edge bypass, register 0 behaviour.
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd7, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0, 1'b0);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Random read/write traffic with frequent address collisions.
    for (int i = 0; i < 150; i++) begin
      wa = 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wa, $urandom,
           ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
           1'b0, 1'b0);
    end

    // Fill rk = k + 0x100 and dump at full rate.
    for (int k = 0; k < 32; k++) step(1'b1, 5'(k), 32'(k + 32'h100), 5'(k), 5'd0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
    guard = 0;
    while (m_active != 0 && guard < 40) begin idle_step(1'b1); guard++; end
    chk("dump1_finished", 32'(m_active), 32'h0);

    // Stall on beat 3 while r3 and r4 are rewritten; start pulses in STREAM are ignored.
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
    guard = 0;
    while (m_idx != 3 && guard < 10) begin idle_step(1'b1); guard++; end
    step(1'b1, 5'd3, 32'h0000AAAA, 5'd3, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd4, 32'h0000BBBB, 5'd3, 5'd4, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    guard = 0;
    while (m_active != 0 && guard < 40) begin idle_step(1'b1); guard++; end
    chk("dump2_finished", 32'(m_active), 32'h0);

    // Random dumps with random backpressure, writes and start requests.
    for (int i = 0; i < 200; i++) begin
      wa = 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wa, $urandom, 5'($urandom_range(0, 31)), wa,
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    guard = 0;
    while (m_active != 0 && guard < 40) begin idle_step(1'b1); guard++; end

    // Reset in the middle of a dump, at beat 10.
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
    guard = 0;
    while (m_idx != 10 && guard < 20) begin idle_step(1'b1); guard++; end
    @(negedge clock);
    #1 reset = 1'b0;
    beat_q.delete();
    m_active = 0;
    m_idx = 0;
    for (int v = 0; v < 2; v++) for (int k = 0; k < 32; k++) mem[v][k] = 32'h0;
    #1;
    chk("midreset_valid", 32'(dv_z | dv_n), 32'h0);
    chk("midreset_busy", 32'(db_z | db_n), 32'h0);
    chk("midreset_done", 32'(dn_z | dn_n), 32'h0);
    chk("midreset_rd", rda_z | rda_n | rdb_z | rdb_n, 32'h0);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) step(1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k), 1'b0, 1'b0);

    idle_step(1'b0);
    @(posedge clock);
    #2;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("beat_queue_drained", 32'(beat_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
